// File: rtl/ycbcr_to_rgb565.sv
// ycbcr_to_rgb565: BT.601 studio-range YCbCr to packed RGB565, 3-stage pipeline with valid/ready backpressure
module ycbcr_to_rgb565 #(
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        y_in,
    input  logic [7:0]        cb_in,
    input  logic [7:0]        cr_in,
    input  logic [USER_W-1:0] user_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [15:0]       rgb565_out,
    output logic [USER_W-1:0] user_out,
    output logic              valid_out,
    input  logic              ready_out
);
    logic                     en;
    logic [7:0]               y_c, cb_c, cr_c;
    logic                     v1, v2;
    logic [USER_W-1:0]        u1, u2;
    logic signed [9:0]        y1, cb1, cr1;
    logic signed [19:0]       rt, gt, bt;

    function automatic logic [7:0] sat(input logic signed [19:0] x);
        return x < 20'sd0 ? 8'd0 : x > 20'sd65535 ? 8'd255 : 8'(x >>> 8);
    endfunction

    assign en       = !valid_out || ready_out;
    assign ready_in = en;

    // saturate inputs to the legal studio range before offset removal
    always_comb begin
        y_c  = y_in  < 8'd16 ? 8'd16 : y_in  > 8'd235 ? 8'd235 : y_in;
        cb_c = cb_in < 8'd16 ? 8'd16 : cb_in > 8'd240 ? 8'd240 : cb_in;
        cr_c = cr_in < 8'd16 ? 8'd16 : cr_in > 8'd240 ? 8'd240 : cr_in;
    end

    // stage 1: remove luma/chroma offsets
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            u1  <= '0;
            y1  <= '0;
            cb1 <= '0;
            cr1 <= '0;
        end else if (en) begin
            v1  <= valid_in;
            u1  <= user_in;
            y1  <= 10'(y_c) - 10'd16;
            cb1 <= 10'(cb_c) - 10'd128;
            cr1 <= 10'(cr_c) - 10'd128;
        end
    end

    // stage 2: 8.8 fixed-point matrix multiply with rounding bias
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            u2 <= '0;
            rt <= '0;
            gt <= '0;
            bt <= '0;
        end else if (en) begin
            v2 <= v1;
            u2 <= u1;
            rt <= 20'sd298 * 20'(y1) + 20'sd409 * 20'(cr1) + 20'sd128;
            gt <= 20'sd298 * 20'(y1) - 20'sd100 * 20'(cb1) - 20'sd208 * 20'(cr1) + 20'sd128;
            bt <= 20'sd298 * 20'(y1) + 20'sd516 * 20'(cb1) + 20'sd128;
        end
    end

    // stage 3: scale, clip to 0..255 and pack to 5:6:5
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            user_out   <= '0;
            rgb565_out <= '0;
        end else if (en) begin
            valid_out  <= v2;
            user_out   <= u2;
            rgb565_out <= {5'(sat(rt) >> 3), 6'(sat(gt) >> 2), 5'(sat(bt) >> 3)};
        end
    end
endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// tb_ycbcr_to_rgb565: vector table, randomized backpressure streams and reset flush checks
module tb_ycbcr_to_rgb565;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  y_in = '0, cb_in = '0, cr_in = '0;
    logic [1:0]  user_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [15:0] rgb565_out;
    logic [1:0]  user_out;
    logic        valid_out;
    logic        ready_out = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    ycbcr_to_rgb565 #(.USER_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
        .user_in(user_in), .valid_in(valid_in), .ready_in(ready_in),
        .rgb565_out(rgb565_out), .user_out(user_out), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  y, cb, cr;
        logic [1:0]  u;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int sat8(input int v);
        return v < 0 ? 0 : v > 255 ? 255 : v;
    endfunction

    function automatic logic [15:0] model(input int y, input int cb, input int cr);
        int yp, cbp, crp, r, g, b;
        yp  = (y < 16 ? 16 : y > 235 ? 235 : y) - 16;
        cbp = (cb < 16 ? 16 : cb > 240 ? 240 : cb) - 128;
        crp = (cr < 16 ? 16 : cr > 240 ? 240 : cr) - 128;
        r = sat8((298 * yp + 409 * crp + 128) >>> 8);
        g = sat8((298 * yp - 100 * cbp - 208 * crp + 128) >>> 8);
        b = sat8((298 * yp + 516 * cbp + 128) >>> 8);
        return 16'(((r >> 3) << 11) | ((g >> 2) << 5) | (b >> 3));
    endfunction

    task automatic run_table();
        vec_t tbl[7];
        int   lat;
        tbl[0] = '{8'd16,  8'd128, 8'd128, 2'b01, 16'h0000};
        tbl[1] = '{8'd235, 8'd128, 8'd128, 2'b10, 16'hFFFF};
        tbl[2] = '{8'd126, 8'd128, 8'd128, 2'b11, 16'h8410};
        tbl[3] = '{8'd81,  8'd90,  8'd240, 2'b00, 16'hF800};
        tbl[4] = '{8'd16,  8'd16,  8'd240, 2'b01, 16'hB000};
        tbl[5] = '{8'd0,   8'd0,   8'd255, 2'b10, 16'hB000};
        tbl[6] = '{8'd255, 8'd255, 8'd255, 2'b11, 16'hFBDF};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", i), valid_out, 0);
            y_in = tbl[i].y; cb_in = tbl[i].cb; cr_in = tbl[i].cr; user_in = tbl[i].u;
            valid_in = 1'b1; ready_out = 1'b1;
            #1;
            chk($sformatf("tbl%0d_ready_in", i), ready_in, 1);
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            valid_in = 1'b0;
            while (!valid_out && lat < 10) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk($sformatf("tbl%0d_latency", i), lat, 3);
            chk($sformatf("tbl%0d_rgb", i), rgb565_out, tbl[i].exp);
            chk($sformatf("tbl%0d_user", i), user_out, tbl[i].u);
        end
    endtask

    task automatic run_stream(input int n, input bit wild);
        logic [17:0] exp_q[$];
        logic [17:0] held, e;
        bit          stall_prev = 0;
        int          i = 0, cyc = 0;
        while ((i < n || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            if (stall_prev) begin
                chk("stall_valid", valid_out, 1);
                chk("stall_hold", {user_out, rgb565_out}, held);
            end
            ready_out = ($urandom % 3) != 0;
            valid_in  = (i < n) && (($urandom % 4) != 0);
            y_in  = wild ? 8'($urandom) : 8'($urandom_range(16, 235));
            cb_in = wild ? 8'($urandom) : 8'($urandom_range(16, 240));
            cr_in = wild ? 8'($urandom) : 8'($urandom_range(16, 240));
            user_in = {i == n - 1, i == 0};
            #1;
            chk("ready_in_rule", ready_in, !(valid_out && !ready_out));
            if (valid_out && ready_out) begin
                chk("stream_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream_rgb", rgb565_out, e[15:0]);
                    chk("stream_user", user_out, e[17:16]);
                end
            end
            if (valid_in && ready_in) begin
                exp_q.push_back({user_in, model(y_in, cb_in, cr_in)});
                i++;
            end
            stall_prev = valid_out && !ready_out;
            held = {user_out, rgb565_out};
            cyc++;
        end
        chk("stream_complete", (i == n) && (exp_q.size() == 0), 1);
        @(negedge clk);
        valid_in = 1'b0; ready_out = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stream_no_dup", valid_out, 0);
        end
    endtask

    task automatic run_reset_flush();
        @(negedge clk);
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            y_in = 8'd200; cb_in = 8'(100 + k * 20); cr_in = 8'd150; user_in = 2'(k + 1);
            valid_in = 1'b1;
            #1;
            chk("flush_ready_in", ready_in, 1);
            @(negedge clk);
        end
        valid_in = 1'b0;
        chk("flush_full_valid", valid_out, 1);
        chk("flush_full_rgb", rgb565_out, model(200, 100, 150));
        rst_n = 1'b0;
        @(negedge clk);
        chk("flush_valid", valid_out, 0);
        chk("flush_rgb", rgb565_out, 0);
        chk("flush_user", user_out, 0);
        rst_n = 1'b1; ready_out = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("flush_no_ghost", valid_out, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", valid_out, 0);
        chk("reset_rgb", rgb565_out, 0);
        chk("reset_user", user_out, 0);
        chk("reset_ready_in", ready_in, 1);
        rst_n = 1'b1;
        run_table();
        run_stream(8, 1'b0);
        run_stream(64, 1'b1);
        run_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ycbcr_to_rgb565.md
Name: ycbcr_to_rgb565

Overview:
- Converts 8-bit YCbCr (ITU-R BT.601 studio range) pixels back to packed RGB565. This is the inverse path of the camera-side RGB565-to-YCbCr converter.
- Sits between the YCbCr processing/overlay stage and the RGB565 display/VGA framebuffer writer.
- 3-stage pipeline with valid/ready backpressure.
- A user sideband (e.g. SOF/EOL flags) travels aligned with each pixel.

Parameters:
- USER_W, 2, width of the sideband bus passed through alongside each pixel (bit0 = SOF, bit1 = EOL by convention).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- y_in  in  8  luma
- cb_in  in  8  blue-difference chroma
- cr_in  in  8  red-difference chroma
- user_in  in  USER_W  sideband, captured with the pixel
- valid_in  in  1  input pixel valid
- ready_in  out  1  block can accept a pixel this cycle
- rgb565_out  out  16  {R[7:3], G[7:2], B[7:3]}
- user_out  out  USER_W  sideband aligned with rgb565_out
- valid_out  out  1  output pixel valid
- ready_out  in  1  downstream accepts the pixel

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All stage valid bits clear; valid_out = 0, rgb565_out = 0, user_out = 0.
  - Data registers clear.
  - Reset mid-stream discards every in-flight pixel; nothing is emitted afterwards for those pixels.
- Pipeline enable: en = !valid_out || ready_out. ready_in = en (combinational).
  - When en = 1, all three stages advance together.
  - When en = 0, all stage registers hold.
- Transfers:
  - Input transfer when valid_in && ready_in.
  - Output transfer when valid_out && ready_out.
- Bubbles are not collapsed. A stage advancing with valid = 0 carries a bubble.
- Latency: exactly 3 clk from input transfer to valid_out when ready_out is held high. Throughput is 1 pixel/clk.
- Stable output: while valid_out = 1 && ready_out = 0, rgb565_out and user_out must not change.
- Stage 1 (offset):
  - Y' = Y − 16, Cb' = Cb − 128, Cr' = Cr − 128, all signed 10-bit.
  - Y is clamped to [16, 235] and Cb/Cr to [16, 240] before the offset, so out-of-range input saturates.
- Stage 2 (multiply-accumulate), signed 20-bit:
  - Rt = 298·Y' + 409·Cr' + 128
  - Gt = 298·Y' − 100·Cb' − 208·Cr' + 128
  - Bt = 298·Y' + 516·Cb' + 128
- Stage 3 (scale, saturate, pack):
  - Each channel = Xt >>> 8 (arithmetic shift).
  - If the result is < 0, use 0. If it is > 255, use 255.
  - Pack R[7:3], G[7:2], B[7:3] into rgb565_out.
  - user_out is registered at this stage.
- user bits are pure pass-through; the block does not interpret them.
- Simultaneous input accept and output drain in one cycle is legal and required at full rate.

Test Plan:
- Y=16, Cb=128, Cr=128, ready_out=1 → rgb565_out=0x0000, valid_out exactly 3 cycles after accept.
- Y=235, Cb=128, Cr=128 → 0xFFFF (R=G=B=255). Y=126, Cb=128, Cr=128 → 0x8410 (R=G=B=128).
- Y=81, Cb=90, Cr=240 (pure red) → 0xF800. This checks G rounding to 0 and B negative-clamp to 0.
- Out-of-range clamp: Y=0, Cb=0, Cr=255 → same output as Y=16, Cb=16, Cr=240.
- Backpressure: stream 8 pixels with user_in SOF on the first and EOL on the last; toggle ready_out randomly. Required:
  - No loss or duplication; order preserved.
  - Outputs held stable while stalled.
  - user_out aligned with its pixel.
  - ready_in low exactly when valid_out && !ready_out.
- Reset with 3 pixels in flight and ready_out=0 → valid_out=0 on the next cycle; none of the 3 pixels appear after reset deasserts.
